// File: rtl/mdu_sequencer_if.sv
// E-stage MDU request/response bundle between the pipeline and the sequencer.
// Holds the decoded operation and operands in, and busy/stall plus HI/LO views out.
interface mdu_sequencer_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_mdu;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_data;

  modport master (
    output start, op, a, b, d_mdu,
    input  busy, stall_req, hi, lo, mf_data
  );

  modport slave (
    input  start, op, a, b, d_mdu,
    output busy, stall_req, hi, lo, mf_data
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer: computes md results on issue, holds them for a fixed
// busy latency, then commits to HI/LO. Also drives the D-stage stall request.
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  mdu_sequencer_if.slave bus
);

  localparam int MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CntW      = ($clog2(MaxCycles + 1) > 4) ? $clog2(MaxCycles + 1) : 4;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_MFHI  = 3'd6,
    MDU_MFLO  = 3'd7
  } mdu_op_e;

  mdu_op_e op;
  assign op = mdu_op_e'(bus.op);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic            dz_q, dz_d;

  // Datapath: results are formed combinationally from the issue-cycle operands.
  logic [63:0] prod_s, prod_u;
  logic [31:0] div_b, mag_a, mag_b, uq, ur, sq, sr, q_u, r_u;

  assign prod_s = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
  assign prod_u = {32'd0, bus.a} * {32'd0, bus.b};

  // A zero divisor is replaced by 1 so the divider never sees x; the commit is suppressed anyway.
  assign div_b = (bus.b == 32'd0) ? 32'd1 : bus.b;
  assign mag_a = bus.a[31] ? -bus.a : bus.a;
  assign mag_b = div_b[31] ? -div_b : div_b;
  assign uq    = mag_a / mag_b;
  assign ur    = mag_a % mag_b;
  assign sq    = (bus.a[31] ^ div_b[31]) ? -uq : uq;
  assign sr    = bus.a[31] ? -ur : ur;
  assign q_u   = bus.a / div_b;
  assign r_u   = bus.a % div_b;

  // NOTE: every architectural register, including the pending result, is reset so an aborted op leaves nothing behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      dz_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      dz_q      <= dz_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default assignments up front prevent latches on paths that leave a register untouched.
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    dz_d      = dz_q;
    if (cnt_q == '0) begin
      if (bus.start) begin
        unique case (op)
          MDU_MULT: begin
            {pend_hi_d, pend_lo_d} = prod_s;
            cnt_d = CntW'(MULT_CYCLES);
            dz_d  = 1'b0;
          end
          MDU_MULTU: begin
            {pend_hi_d, pend_lo_d} = prod_u;
            cnt_d = CntW'(MULT_CYCLES);
            dz_d  = 1'b0;
          end
          MDU_DIV: begin
            pend_hi_d = sr;
            pend_lo_d = sq;
            cnt_d     = CntW'(DIV_CYCLES);
            dz_d      = (bus.b == 32'd0);
          end
          MDU_DIVU: begin
            pend_hi_d = r_u;
            pend_lo_d = q_u;
            cnt_d     = CntW'(DIV_CYCLES);
            dz_d      = (bus.b == 32'd0);
          end
          MDU_MTHI: hi_d = bus.a;
          MDU_MTLO: lo_d = bus.a;
          default: ;
        endcase
      end
    end else begin
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1) && !dz_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end
  end

  always_comb begin
    bus.busy      = (cnt_q != '0);
    bus.stall_req = bus.d_mdu & ((cnt_q != '0) | (bus.start & ~bus.op[2]));
    bus.hi        = hi_q;
    bus.lo        = lo_q;
    bus.mf_data   = (op == MDU_MFHI) ? hi_q : lo_q;
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed cases plus randomized ops
// compared against an arithmetic reference model of HI/LO and latency.
module tb_mdu_sequencer;
  localparam int MultN = 5;
  localparam int DivN  = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_sequencer_if mif ();

  mdu_sequencer #(.MULT_CYCLES(MultN), .DIV_CYCLES(DivN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (mif.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (reset_n) assert (!(mif.start && mif.busy)) else $error("start asserted while busy");

  // Reference: plain 64-bit arithmetic; returns {hi,lo} and whether a commit happens.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, output logic upd);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] res;
    upd = 1'b1;
    res = {m_hi, m_lo};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: res = 64'(sa * sb);
      3'd1: res = 64'(ua * ub);
      3'd2: if (b == 0) upd = 1'b0;
            else begin sq = sa / sb; sr = sa % sb; res = {sr[31:0], sq[31:0]}; end
      3'd3: if (b == 0) upd = 1'b0;
            else begin uq = ua / ub; ur = ua % ub; res = {ur[31:0], uq[31:0]}; end
      default: upd = 1'b0;
    endcase
    return res;
  endfunction

  // Issues an md op at a negedge; counts busy and stall cycles; checks HI/LO vs model.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic dm, output int ncyc, output int nstall);
    logic [63:0] exp;
    logic upd;
    exp = model(op, a, b, upd);
    mif.start = 1'b1; mif.op = op; mif.a = a; mif.b = b; mif.d_mdu = dm;
    #1;
    nstall = mif.stall_req ? 1 : 0;
    @(negedge clk);
    mif.start = 1'b0;
    ncyc = 0;
    while (mif.busy && ncyc < 40) begin
      ncyc++;
      if (mif.stall_req) nstall++;
      if (mif.hi !== m_hi || mif.lo !== m_lo) begin
        errors++;
        $display("FAIL md_early_commit op=%0d hi=%h lo=%h required hi=%h lo=%h", op, mif.hi, mif.lo, m_hi, m_lo);
      end
      checks++;
      @(negedge clk);
    end
    if (upd) begin m_hi = exp[63:32]; m_lo = exp[31:0]; end
    checks++;
    if (mif.hi !== m_hi || mif.lo !== m_lo) begin
      errors++;
      $display("FAIL md_result op=%0d a=%h b=%h hi=%h lo=%h required hi=%h lo=%h", op, a, b, mif.hi, mif.lo, m_hi, m_lo);
    end
    checks++;
    if (ncyc !== ((op < 3'd2) ? MultN : DivN)) begin
      errors++;
      $display("FAIL md_latency op=%0d got %0d required %0d", op, ncyc, (op < 3'd2) ? MultN : DivN);
    end
    checks++;
    if (mif.stall_req !== 1'b0) begin
      errors++;
      $display("FAIL stall_after_done got %b required 0", mif.stall_req);
    end
  endtask

  task automatic do_mt(input logic hi_sel, input logic [31:0] a);
    mif.start = 1'b1; mif.op = hi_sel ? 3'd4 : 3'd5; mif.a = a; mif.b = $urandom;
    #1;
    checks++;
    if (mif.stall_req !== 1'b0 || mif.busy !== 1'b0) begin
      errors++;
      $display("FAIL mt_no_stall stall=%b busy=%b required 0/0", mif.stall_req, mif.busy);
    end
    @(negedge clk);
    mif.start = 1'b0;
    if (hi_sel) m_hi = a; else m_lo = a;
    checks++;
    if (mif.hi !== m_hi || mif.lo !== m_lo) begin
      errors++;
      $display("FAIL mt_write hi=%h lo=%h required hi=%h lo=%h", mif.hi, mif.lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset();
    mif.start = 1'b0; mif.op = 3'd0; mif.a = '0; mif.b = '0; mif.d_mdu = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (mif.busy !== 1'b0 || mif.hi !== 32'd0 || mif.lo !== 32'd0 || mif.stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_state busy=%b hi=%h lo=%h stall=%b required 0/0/0/0", mif.busy, mif.hi, mif.lo, mif.stall_req);
    end
    mif.d_mdu = 1'b1; mif.start = 1'b1; mif.op = 3'd2;
    #1;
    checks++;
    if (mif.stall_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall_comb got %b required 1", mif.stall_req);
    end
    mif.start = 1'b0; mif.d_mdu = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int n, s;
    run_md(3'd0, 32'hFFFFFFFD, 32'd5, 1'b0, n, s);
    checks++;
    if (mif.hi !== 32'hFFFFFFFF || mif.lo !== 32'hFFFFFFF1) begin
      errors++;
      $display("FAIL mult_directed hi=%h lo=%h required FFFFFFFF/FFFFFFF1", mif.hi, mif.lo);
    end
    run_md(3'd1, 32'hFFFFFFFD, 32'd5, 1'b0, n, s);
    checks++;
    if (mif.hi !== 32'h00000004 || mif.lo !== 32'hFFFFFFF1) begin
      errors++;
      $display("FAIL multu_directed hi=%h lo=%h required 00000004/FFFFFFF1", mif.hi, mif.lo);
    end
  endtask

  task automatic test_div();
    int n, s;
    run_md(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, n, s);
    checks++;
    if (mif.hi !== 32'hFFFFFFFF || mif.lo !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL div_directed hi=%h lo=%h required FFFFFFFF/FFFFFFFD", mif.hi, mif.lo);
    end
    run_md(3'd3, 32'd7, 32'd2, 1'b0, n, s);
    checks++;
    if (mif.hi !== 32'd1 || mif.lo !== 32'd3) begin
      errors++;
      $display("FAIL divu_directed hi=%h lo=%h required 1/3", mif.hi, mif.lo);
    end
    run_md(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, n, s);
    checks++;
    if (mif.hi !== 32'd0 || mif.lo !== 32'h80000000) begin
      errors++;
      $display("FAIL div_overflow hi=%h lo=%h required 0/80000000", mif.hi, mif.lo);
    end
  endtask

  task automatic test_div_zero();
    int n, s;
    do_mt(1'b1, 32'h1234);
    run_md(3'd3, 32'd5, 32'd0, 1'b0, n, s);
    checks++;
    if (mif.hi !== 32'h1234 || mif.lo !== 32'h80000000) begin
      errors++;
      $display("FAIL divu_by_zero hi=%h lo=%h required 1234/80000000", mif.hi, mif.lo);
    end
    run_md(3'd2, 32'hFFFF0000, 32'd0, 1'b0, n, s);
  endtask

  task automatic test_stall();
    int n, s;
    run_md(3'd0, $urandom, $urandom, 1'b1, n, s);
    checks++;
    if (s !== MultN + 1) begin
      errors++;
      $display("FAIL stall_length got %0d required %0d", s, MultN + 1);
    end
    mif.start = 1'b1; mif.op = 3'd7; mif.d_mdu = 1'b1;
    #1;
    checks++;
    if (mif.stall_req !== 1'b0) begin
      errors++;
      $display("FAIL mf_idle_stall got %b required 0", mif.stall_req);
    end
    @(negedge clk);
    mif.start = 1'b0; mif.d_mdu = 1'b0;
  endtask

  task automatic test_mf();
    do_mt(1'b0, 32'hDEADBEEF);
    mif.op = 3'd7;
    #1;
    checks++;
    if (mif.mf_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL mflo_read got %h required DEADBEEF", mif.mf_data);
    end
    mif.op = 3'd6;
    #1;
    checks++;
    if (mif.mf_data !== m_hi) begin
      errors++;
      $display("FAIL mfhi_read got %h required %h", mif.mf_data, m_hi);
    end
    mif.op = 3'd2;
    #1;
    checks++;
    if (mif.mf_data !== m_lo) begin
      errors++;
      $display("FAIL mf_default_lo got %h required %h", mif.mf_data, m_lo);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n, s;
    run_md(3'd1, $urandom, $urandom, 1'b1, n, s);
    run_md(3'd3, $urandom, $urandom_range(1, 1000), 1'b1, n, s);
    checks++;
    if (s !== DivN + 1) begin
      errors++;
      $display("FAIL b2b_stall got %0d required %0d", s, DivN + 1);
    end
    mif.d_mdu = 1'b0;
  endtask

  task automatic test_random();
    int n, s;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        dm;
    for (int i = 0; i < 120; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom);
      dm = 1'($urandom_range(0, 1));
      if (op <= 3'd3) begin
        run_md(op, a, b, dm, n, s);
        checks++;
        if (s !== (dm ? n + 1 : 0)) begin
          errors++;
          $display("FAIL rand_stall op=%0d dm=%b got %0d required %0d", op, dm, s, dm ? n + 1 : 0);
        end
      end else if (op <= 3'd5) begin
        do_mt(op == 3'd4, a);
      end else begin
        mif.start = 1'b1; mif.op = op; mif.d_mdu = dm;
        #1;
        checks++;
        if (mif.mf_data !== ((op == 3'd6) ? m_hi : m_lo) || mif.stall_req !== 1'b0) begin
          errors++;
          $display("FAIL rand_mf op=%0d data=%h stall=%b required %h/0", op, mif.mf_data, mif.stall_req, (op == 3'd6) ? m_hi : m_lo);
        end
        @(negedge clk);
        mif.start = 1'b0;
      end
      mif.d_mdu = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    do_mt(1'b1, 32'hA5A5A5A5);
    do_mt(1'b0, 32'h5A5A5A5A);
    mif.start = 1'b1; mif.op = 3'd0; mif.a = 32'd7; mif.b = 32'd9; mif.d_mdu = 1'b0;
    @(negedge clk);
    mif.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (mif.busy !== 1'b0 || mif.hi !== 32'd0 || mif.lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_op busy=%b hi=%h lo=%h required 0/0/0", mif.busy, mif.hi, mif.lo);
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_hi = '0; m_lo = '0;
    repeat (MultN + 3) @(negedge clk);
    checks++;
    if (mif.busy !== 1'b0 || mif.hi !== 32'd0 || mif.lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_discard busy=%b hi=%h lo=%h required 0/0/0", mif.busy, mif.hi, mif.lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_stall();
    test_mf();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multiply/divide sequencer for the P6 pipeline's E stage. It accepts decoded MDU operations (`MDUOp`, `MDU_start`) with the rs/rt operands. It models multi-cycle mult/div latency with a busy counter and owns the HI/LO architectural registers. It also produces the D-stage stall request that the hazard unit ORs into its global stall.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (must be >= 1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (must be >= 1).

Ports:
- `clk` input 1: system clock, rising edge.
- `reset_n` input 1: one clock; reset is asynchronous and active-low.
- `start` input 1: E-stage MDU instruction valid this cycle (driven by `MDU_start` or any mt/mf).
- `op` input 3: `MDU_*` encoding: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo.
- `a` input 32: rs operand (forwarded).
- `b` input 32: rt operand (forwarded).
- `d_mdu` input 1: the D-stage instruction is md, mt or mf.
- `busy` output 1: an operation is in flight.
- `stall_req` output 1: stall D stage.
- `hi`, `lo` output 32 each: current HI/LO.
- `mf_data` output 32: `hi` when op==6, `lo` when op==7, else `lo`.

## Operation
- Internal state:
  - `cnt` (4 bits minimum, sized to the max parameter).
  - `pend_hi`/`pend_lo` (32 each).
  - `hi`/`lo`.
- States are implied by `cnt`: IDLE (`cnt==0`) and RUN (`cnt!=0`). `busy = (cnt != 0)`.
- IDLE with `start` and an md op (0-3):
  - Compute the result into `pend_hi`/`pend_lo`.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES.
  - HI/LO are untouched until completion.
- mult: signed 32x32 -> 64; `pend_hi` = [63:32], `pend_lo` = [31:0].
- multu: the same, unsigned.
- div: signed; `pend_lo` = quotient truncated toward zero; `pend_hi` = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient and remainder.
- Divisor == 0 (div/divu):
  - The counter still runs the full DIV_CYCLES.
  - At completion HI/LO keep their old values.
- mthi/mtlo with `start` in IDLE: write `a` to hi/lo at the next edge. No busy.
- mfhi/mflo: combinational read via `mf_data`. No state change.
- RUN: `cnt` decrements each edge. On the edge where `cnt==1`, `hi<=pend_hi` and `lo<=pend_lo` (unless div-by-zero), and `cnt<=0`.
- `start` while busy: ignored, no state change. The hazard unit guarantees this never happens; the bench flags it as an assertion.
- `stall_req = d_mdu & (busy | (start & (op <= 3)))` (combinational).
  - mt/mf in E do not by themselves stall a D-stage MDU instruction.

## Timing
- Reset (async, any time, including mid-operation):
  - `cnt=0`, `busy=0`, `stall_req` driven only by the inputs.
  - `hi=lo=0`, `pend_*=0`.
  - The in-flight result is discarded.
- Latency for an md op sampled at edge T0:
  - `busy`=1 in cycles T0+1 .. T0+N.
  - New HI/LO are visible from edge T0+N, the same cycle `busy` falls.
  - A back-to-back md op may start at edge T0+N.
- `stall_req` asserts in the cycle the md op sits in E (before the T0 edge) and stays high through the last busy cycle.
  - Total D-stage stall is N+1 cycles when `d_mdu` is held.
- mthi/mtlo: `hi`/`lo` update at the sampling edge, visible the next cycle.
- `mf_data` has zero latency from `op`/`hi`/`lo`.

## Test plan
- mult a=0xFFFFFFFD (-3), b=5 -> `busy` high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1; multu on the same operands -> hi=0x00000004, lo=0xFFFFFFF1.
- div a=0xFFFFFFF9 (-7), b=2 -> 10 busy cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7, b=2 -> lo=3, hi=1; div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload hi=0x1234 via mthi; divu a=5, b=0 -> busy 10 cycles; hi stays 0x1234 and lo is unchanged.
- mult issued with `d_mdu`=1 held -> `stall_req` high in the issue cycle plus 5 busy cycles (6 total), low the cycle after; mflo in E with `d_mdu`=1 and idle -> `stall_req`=0.
- mtlo a=0xDEADBEEF, then op=7 -> `mf_data`=0xDEADBEEF the next cycle; op=6 -> the current hi.
- Start mult, drive `reset_n` low at busy cycle 3 -> `busy`=0 and hi=lo=0 immediately; after release no HI/LO write occurs.
